clk_divider_multi: RTL and testbench
====================================

// Module: clk_divider_multi
// PURPOSE
//   NUM_CH independent programmable clock dividers in the clk_in domain.
//   Each channel produces a registered divided clock level and a 1-cycle
//   tick enable. Divisors are reloaded at run time over a valid/ready port.
//   New divisors take effect only at period boundaries, so no output glitches.
//   A common sync input re-phases all running channels.
// PARAMETERS
//   NUM_CH      4    number of divider channels (>=1)
//   CNT_W       32   divisor/counter width; legal divisor 2..2^CNT_W-1
//   DEFAULT_DIV 10   divisor loaded into every channel at reset (>=2)
// PORTS
//   clk_in      in   1        single clock; all logic on posedge
//   rst         in   1        synchronous, active-high reset
//   en          in   NUM_CH   per-channel run enable
//   sync        in   1        restart all running channels at period start
//   cfg_valid   in   1        divisor update request
//   cfg_ready   out  1        = !pend[cfg_ch] (combinational); 1 if cfg_ch out of range
//   cfg_ch      in   CH_W     target channel, CH_W = max(1,$clog2(NUM_CH))
//   cfg_div     in   CNT_W    requested divisor D
//   cfg_err     out  1        1-cycle pulse: accepted request rejected
//   pend        out  NUM_CH   channel has an accepted, not-yet-applied divisor
//   div_clk     out  NUM_CH   divided clock level, registered
//   tick        out  NUM_CH   1-cycle pulse on first cycle of each period
// BEHAVIOUR
//   Reset (rst=1 at posedge): D[i]=DEFAULT_DIV, cnt=0, run=0, pend=0.
//     Outputs: div_clk=0, tick=0, cfg_err=0.
//   Per channel, H = (D+1)>>1 cycles high, D-H low; period = D cycles.
//   Accept: cfg_valid & cfg_ready.
//     If cfg_div<2 or cfg_ch>=NUM_CH: cfg_err=1 next cycle, no other change.
//     Else: store cfg_div in pend_div[cfg_ch] and set pend.
//   Apply point: pend_div->D, pend cleared, on any posedge where the channel
//     (a) has run=0, (b) has run=1 & cnt==D-1, or (c) sync=1 & run=1.
//     The new period's outputs use the new D.
//   Channel state per posedge, priority order:
//     en=0            : run<=0 cnt<=0 div_clk<=0 tick<=0
//     en=1, run=0     : run<=1 cnt<=0 div_clk<=1 tick<=1 (1 cycle latency)
//     en=1, sync=1    : cnt<=0 div_clk<=1 tick<=1
//     en=1, cnt==D-1  : cnt<=0 div_clk<=1 tick<=1
//     otherwise       : cnt<=cnt+1 div_clk<=(cnt+1<H) tick<=0
//   Invariant while run=1: div_clk==(cnt<H) and tick==(cnt==0 & period start).
//   Counter never exceeds D-1; no wrap past 2^CNT_W. D is compared at full width.
//   Accept and apply on the same cycle (pend=0 before): request waits.
//     It is applied at the next apply point, not the current one.
//   rst mid-period or mid-handshake: everything returns to reset state.
//     Any pending divisor is dropped.
//   cfg_ch has no effect on channels other than the addressed one.
// TESTING
//   1 Reset, en=0001, D default 10: div_clk[0] 5 high/5 low repeating.
//     tick[0] every 10 cycles, first tick 1 cycle after en rises.
//   2 Odd divisor: load D=7 on ch1 while idle, then enable.
//     Expect 4 high/3 low, tick period 7.
//   3 Load D=4 on ch0 mid-period (cnt=2 of 10): pend[0]=1, cfg_ready=0 for ch0.
//     Current period completes at 10. Following periods are 2/2. pend clears at the boundary.
//   4 cfg_div=1 and cfg_ch=NUM_CH: cfg_err pulses once each.
//     D unchanged, pend stays 0.
//   5 ch0 D=10 and ch2 D=6 running, sync at arbitrary cycle.
//     Next cycle both tick=1, div_clk=1, cnt=0. ch3 with en=0 stays 0.
//   6 rst asserted with pend[2]=1 mid-period: all outputs 0 next cycle.
//     D[2]=DEFAULT_DIV after restart.

Source files
------------

// File: rtl/clk_divider_multi_if.sv
// Divisor reload port for clk_divider_multi: valid/ready request plus a
// one-cycle error pulse for requests that were accepted but rejected.
interface clk_divider_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_divider_multi.sv
// NUM_CH independent programmable clock dividers with glitch-free divisor
// reload at period boundaries and a common re-phasing sync input.
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 10,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    clk_divider_multi_if.slave cfg,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick
);
    localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] pend_vec;
    logic              cfg_accept;
    logic              cfg_bad;
    logic              cfg_err_reg;

    // An out-of-range channel selects nothing, so ready stays high and the
    // request is rejected through cfg_err instead of stalling the port.
    assign cfg.cfg_ready = ~|(pend_vec & ch_sel);
    assign cfg_accept    = cfg.cfg_valid & cfg.cfg_ready;
    assign cfg_bad       = (cfg.cfg_div < CNT_W'(2)) | ~|ch_sel;
    assign cfg.cfg_err   = cfg_err_reg;
    assign pend          = pend_vec;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_accept & cfg_bad;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] div_reg;
            logic [CNT_W-1:0] pend_div_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             run_reg;
            logic             pend_reg;
            logic             div_clk_reg;
            logic             tick_reg;
            logic [CNT_W:0]   half;
            logic [CNT_W:0]   cnt_inc;
            logic             at_end;
            logic             apply_now;
            logic             load_now;

            assign ch_sel[gi]   = (cfg.cfg_ch == CH_W'(gi));
            assign pend_vec[gi] = pend_reg;
            assign div_clk[gi]  = div_clk_reg;
            assign tick[gi]     = tick_reg;

            // Widened by one bit so odd divisors near 2^CNT_W-1 round up cleanly.
            assign half    = ({1'b0, div_reg} + ONE_W) >> 1;
            assign cnt_inc = {1'b0, cnt_reg} + ONE_W;
            assign at_end  = (cnt_reg == div_reg - CNT_W'(1));

            // Accept needs pend clear and apply needs pend set, so a request
            // accepted on an apply point is held for the following one.
            assign apply_now = pend_reg & (~run_reg | at_end | sync);
            assign load_now  = cfg_accept & ~cfg_bad & ch_sel[gi];

            always_ff @(posedge clk_in) begin
                if (rst) begin
                    div_reg      <= DEF_D;
                    pend_div_reg <= DEF_D;
                    pend_reg     <= 1'b0;
                    cnt_reg      <= '0;
                    run_reg      <= 1'b0;
                    div_clk_reg  <= 1'b0;
                    tick_reg     <= 1'b0;
                end else begin
                    if (load_now) begin
                        pend_div_reg <= cfg.cfg_div;
                        pend_reg     <= 1'b1;
                    end else if (apply_now) begin
                        div_reg  <= pend_div_reg;
                        pend_reg <= 1'b0;
                    end

                    if (!en[gi]) begin
                        run_reg     <= 1'b0;
                        cnt_reg     <= '0;
                        div_clk_reg <= 1'b0;
                        tick_reg    <= 1'b0;
                    end else if (!run_reg || sync || at_end) begin
                        run_reg     <= 1'b1;
                        cnt_reg     <= '0;
                        div_clk_reg <= 1'b1;
                        tick_reg    <= 1'b1;
                    end else begin
                        cnt_reg     <= cnt_inc[CNT_W-1:0];
                        div_clk_reg <= (cnt_inc < half);
                        tick_reg    <= 1'b0;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: default divide, odd divisor, mid-period
// reload, rejected requests, sync re-phasing and reset with a pending divisor.
module tb_clk_divider_multi;
    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    logic [3:0] en;
    logic       sync;
    logic [3:0] pend, div_clk, tick;

    logic [2:0] en3;
    logic [2:0] pend3, div_clk3, tick3;

    clk_divider_multi_if #(.NUM_CH(4), .CNT_W(32), .CH_W(2)) cfg_bus ();
    clk_divider_multi_if #(.NUM_CH(3), .CNT_W(32), .CH_W(2)) cfg3_bus ();

    clk_divider_multi #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(10)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .cfg    (cfg_bus),
        .pend   (pend),
        .div_clk(div_clk),
        .tick   (tick)
    );

    // Three-channel copy: lets a 2-bit cfg_ch address a channel that does not exist.
    clk_divider_multi #(.NUM_CH(3), .CNT_W(32), .DEFAULT_DIV(10)) dut3 (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en3),
        .sync   (sync),
        .cfg    (cfg3_bus),
        .pend   (pend3),
        .div_clk(div_clk3),
        .tick   (tick3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en = 4'b0000;
        en3 = 3'b000;
        sync = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch = 2'd0;
        cfg_bus.cfg_div = 32'd0;
        cfg3_bus.cfg_valid = 1'b0;
        cfg3_bus.cfg_ch = 2'd0;
        cfg3_bus.cfg_div = 32'd0;
        repeat (3) cyc();

        // Reset state
        chk("rst_div_clk", div_clk, 4'b0000);
        chk("rst_tick", tick, 4'b0000);
        chk("rst_pend", pend, 4'b0000);
        chk("rst_cfg_err", cfg_bus.cfg_err, 1'b0);
        chk("rst_cfg_ready", cfg_bus.cfg_ready, 1'b1);
        chk("rst3_div_clk", div_clk3, 3'b000);
        rst = 1'b0;
        cyc();
        $display("step reset: div_clk=%b tick=%b pend=%b", div_clk, tick, pend);

        // 1: default divisor 10 on ch0, 5 high / 5 low
        en = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk("t1_div_clk0", div_clk[0], ((c % 10) < 5));
            chk("t1_tick0", tick[0], ((c % 10) == 0));
            chk("t1_others", {div_clk[3:1], tick[3:1]}, 6'b0);
        end
        $display("step 1: default divide-by-10 on ch0 checked over 20 cycles");

        // 2: load D=7 on idle ch1, then run it: 4 high / 3 low
        en = 4'b0000;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 2'd1;
        cfg_bus.cfg_div = 32'd7;
        #1;
        chk("t2_ready", cfg_bus.cfg_ready, 1'b1);
        cyc();
        chk("t2_pend_set", pend, 4'b0010);
        chk("t2_div_clk_off", div_clk, 4'b0000);
        cfg_bus.cfg_valid = 1'b0;
        cyc();
        chk("t2_pend_applied", pend, 4'b0000);
        en = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            cyc();
            chk("t2_div_clk1", div_clk[1], ((c % 7) < 4));
            chk("t2_tick1", tick[1], ((c % 7) == 0));
            chk("t2_div_clk0", div_clk[0], 1'b0);
        end
        en = 4'b0000;
        cyc();
        chk("t2_stop", div_clk, 4'b0000);
        $display("step 2: ch1 divide-by-7 checked over 14 cycles");

        // 3: D=4 on ch0 requested at cnt=2 of a 10-cycle period
        en = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("t3_pre_div_clk0", div_clk[0], 1'b1);
            chk("t3_pre_tick0", tick[0], (c == 0));
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 2'd0;
        cfg_bus.cfg_div = 32'd4;
        #1;
        chk("t3_ready_before", cfg_bus.cfg_ready, 1'b1);
        cyc();
        chk("t3_pend_set", pend, 4'b0001);
        chk("t3_ready_busy", cfg_bus.cfg_ready, 1'b0);
        chk("t3_div_clk_cnt3", div_clk[0], 1'b1);
        cfg_bus.cfg_valid = 1'b0;
        for (int k = 4; k < 10; k++) begin
            cyc();
            chk("t3_old_div_clk0", div_clk[0], (k < 5));
            chk("t3_old_tick0", tick[0], 1'b0);
            chk("t3_old_pend", pend, 4'b0001);
        end
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("t3_new_div_clk0", div_clk[0], ((c % 4) < 2));
            chk("t3_new_tick0", tick[0], ((c % 4) == 0));
            chk("t3_new_pend", pend, 4'b0000);
        end
        $display("step 3: mid-period reload to 4 applied at boundary");

        // 4: rejected requests (divisor 1, channel out of range)
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 2'd0;
        cfg_bus.cfg_div = 32'd1;
        cfg3_bus.cfg_valid = 1'b1;
        cfg3_bus.cfg_ch = 2'd3;
        cfg3_bus.cfg_div = 32'd5;
        #1;
        chk("t4_ready_oor", cfg3_bus.cfg_ready, 1'b1);
        cyc();
        chk("t4_err_div1", cfg_bus.cfg_err, 1'b1);
        chk("t4_err_oor", cfg3_bus.cfg_err, 1'b1);
        chk("t4_tick0", tick[0], 1'b1);
        cfg_bus.cfg_valid = 1'b0;
        cfg3_bus.cfg_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            cyc();
            chk("t4_err_once", cfg_bus.cfg_err, 1'b0);
            chk("t4_err3_once", cfg3_bus.cfg_err, 1'b0);
            chk("t4_pend", pend, 4'b0000);
            chk("t4_pend3", pend3, 3'b000);
            chk("t4_div_clk0", div_clk[0], ((c % 4) < 2));
            chk("t4_tick0_keep", tick[0], ((c % 4) == 0));
        end
        $display("step 4: invalid divisor and out-of-range channel rejected");

        // 5: ch0 D=10, ch2 D=6, sync mid-period
        en = 4'b0000;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 2'd0;
        cfg_bus.cfg_div = 32'd10;
        cyc();
        cfg_bus.cfg_ch = 2'd2;
        cfg_bus.cfg_div = 32'd6;
        cyc();
        cfg_bus.cfg_valid = 1'b0;
        cyc();
        chk("t5_pend_clear", pend, 4'b0000);
        en = 4'b0101;
        for (int c = 0; c < 14; c++) begin
            cyc();
            chk("t5_div_clk0", div_clk[0], ((c % 10) < 5));
            chk("t5_div_clk2", div_clk[2], ((c % 6) < 3));
            chk("t5_tick", tick, {1'b0, ((c % 6) == 0), 1'b0, ((c % 10) == 0)});
            chk("t5_ch3", div_clk[3], 1'b0);
        end
        sync = 1'b1;
        cyc();
        chk("t5_sync_div_clk", div_clk, 4'b0101);
        chk("t5_sync_tick", tick, 4'b0101);
        sync = 1'b0;
        for (int c = 1; c < 13; c++) begin
            cyc();
            chk("t5_post_div_clk0", div_clk[0], ((c % 10) < 5));
            chk("t5_post_div_clk2", div_clk[2], ((c % 6) < 3));
            chk("t5_post_tick", tick, {1'b0, ((c % 6) == 0), 1'b0, ((c % 10) == 0)});
        end
        $display("step 5: sync re-phased ch0 and ch2, ch3 idle");

        // 6: reset with pend[2] set mid-period drops the pending divisor
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 2'd2;
        cfg_bus.cfg_div = 32'd3;
        cyc();
        chk("t6_pend_set", pend, 4'b0100);
        cfg_bus.cfg_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("t6_rst_div_clk", div_clk, 4'b0000);
        chk("t6_rst_tick", tick, 4'b0000);
        chk("t6_rst_pend", pend, 4'b0000);
        chk("t6_rst_err", cfg_bus.cfg_err, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk("t6_div_clk2", div_clk[2], ((c % 10) < 5));
            chk("t6_tick2", tick[2], ((c % 10) == 0));
            chk("t6_pend", pend, 4'b0000);
        end
        $display("step 6: reset dropped pending divisor, ch2 back to 10");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
